// File: rtl/alu_share_arbiter.sv
`timescale 1ns/1ps
// alu_share_arbiter
// Shares one combinational ALU between two requesters. Requests are
// arbitrated round-robin, their operands latched, the ALU result captured
// one cycle later and returned on the winner's response channel. Only one
// operation is in flight at a time.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready [1:0]  per-requester request handshake
//   req_op1_x/req_op2_x/req_sel_x  requester x operands and function select
//   resp_valid/resp_ready [1:0]    per-requester response handshake
//   resp_data                  result for the asserted resp_valid bit
//   alu_operand1/2, alu_sel    to the shared ALU (always the latched values)
//   alu_result                 from the shared ALU
//   busy                       high whenever an operation is in flight
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_op1_0,
  input  logic [WIDTH-1:0] req_op2_0,
  input  logic [SEL_W-1:0] req_sel_0,
  input  logic [WIDTH-1:0] req_op1_1,
  input  logic [WIDTH-1:0] req_op2_1,
  input  logic [SEL_W-1:0] req_sel_1,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic [WIDTH-1:0] alu_operand1,
  output logic [WIDTH-1:0] alu_operand2,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] op1_q;
  logic [WIDTH-1:0] op2_q;
  logic [SEL_W-1:0] sel_q;
  logic [WIDTH-1:0] result_q;
  logic             owner_q;
  logic             rr_ptr_q;

  logic             grant_d;
  logic [1:0]       grant_oh_d;
  logic             accept_d;

  // Grant is resolved combinationally while idle; rr_ptr only matters on a tie.
  always_comb begin
    grant_d    = (req_valid == 2'b11) ? rr_ptr_q : req_valid[1];
    grant_oh_d = grant_d ? 2'b10 : 2'b01;
    req_ready  = '0;
    // rst_n gating keeps ready low for the whole reset window, not just after it.
    if (rst_n && (state_q == IDLE) && (req_valid != 2'b00)) begin
      req_ready = grant_oh_d;
    end
    accept_d = |(req_valid & req_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op1_q    <= '0;
      op2_q    <= '0;
      sel_q    <= '0;
      result_q <= '0;
      owner_q  <= 1'b0;
      rr_ptr_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            op1_q   <= grant_d ? req_op1_1 : req_op1_0;
            op2_q   <= grant_d ? req_op2_1 : req_op2_0;
            sel_q   <= grant_d ? req_sel_1 : req_sel_0;
            owner_q <= grant_d;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          result_q <= alu_result;
          state_q  <= RESP;
        end
        RESP: begin
          // Only the owner's ready completes the response.
          if (resp_ready[owner_q]) begin
            rr_ptr_q <= ~owner_q;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_operand1 = op1_q;
  assign alu_operand2 = op2_q;
  assign alu_sel      = sel_q;
  assign resp_data    = result_q;
  assign resp_valid   = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign busy         = (state_q != IDLE);

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational `alu` instance between two requesters, e.g. the integer pipeline (port 0) and an address/branch-offset helper (port 1).
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- The block arbitrates round-robin, registers operands, drives the shared ALU, captures its result and returns it to the winning requester.
- Only one operation is in flight at a time.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SEL_W, 4, width of the ALU function select (encoding passed through untouched).

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  2  per-requester request valid (bit i = requester i)
- req_ready  output  2  per-requester request accepted this cycle
- req_op1_0, req_op2_0  input  WIDTH each  requester 0 operands
- req_sel_0  input  SEL_W  requester 0 ALU function select
- req_op1_1, req_op2_1  input  WIDTH each  requester 1 operands
- req_sel_1  input  SEL_W  requester 1 ALU function select
- resp_valid  output  2  per-requester result valid
- resp_ready  input  2  per-requester result accepted
- resp_data  output  WIDTH  result, meaningful only for the asserted resp_valid bit
- alu_operand1, alu_operand2  output  WIDTH each  to shared ALU operand1/operand2
- alu_sel  output  SEL_W  to shared ALU alu_sel
- alu_result  input  WIDTH  from shared ALU alu_out
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE
  - operand/select/result registers = 0
  - owner = 0
  - rr_ptr = 0, so requester 0 has priority first
  - resp_valid = 2'b00, busy = 0, req_ready = 2'b00
- Reset mid-operation discards the in-flight operation; no response is ever produced for it.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational from req_valid and rr_ptr.
  - If only one bit of req_valid is set, that requester is granted.
  - If both are set, requester rr_ptr is granted.
  - req_ready[grant] = 1 in the same cycle; the other bit is 0.
  - Handshake on (valid & ready): latch op1/op2/sel of the granted port, set owner = grant, go to EXEC.
  - With no valid set, stay in IDLE and req_ready = 0.
- EXEC (exactly 1 cycle):
  - alu_operand1/alu_operand2/alu_sel are driven from the latched registers.
  - At the clock edge, alu_result is registered into the result register; go to RESP.
- RESP:
  - resp_valid[owner] = 1; resp_data = result register.
  - Both stay stable until resp_ready[owner] = 1.
  - resp_ready on the non-owner bit is ignored.
  - On completion: rr_ptr = ~owner, go to IDLE.
- req_ready = 0 in EXEC and RESP; a new request is never accepted in the same cycle a response completes.
- Latency: request accepted at edge N; resp_valid is high from cycle N+2. Maximum throughput is one op per 3 cycles when resp_ready is held high.
- ALU-facing outputs always reflect the latched registers, so they stay stable outside EXEC and hold the last operation's values.
- Requesters hold req_valid and their operands stable until the ready handshake. A request withdrawn before its grant is simply not served.
- Starvation bound: a requester with continuous req_valid is served within 2 operations.
- Arithmetic: none performed here. Select codes pass through unmodified, including undefined codes (the ALU treats these as "pass operand2").

Test Plan:
- **Single add:** requester 0 sends op1=5, op2=7, sel=4'b0000, resp_ready=1 → req_ready[0] high in the request cycle; alu_sel=0 during EXEC; resp_valid[0] two cycles later with resp_data=12; busy high for 2 cycles.
- **Simultaneous requests:** both valid after reset; r0 sends SUB 10-3 (sel 4'b1000), r1 sends XOR 0xF0^0x0F (sel 4'b0100) → r0 served first with 7, then r1 with 0xFF; with both held valid, service alternates 0,1,0,1.
- **Response backpressure:** r1 sends SLT -1<1 (0xFFFFFFFF, 1, sel 4'b0010) with resp_ready[1]=0 for 5 cycles → resp_valid[1] and resp_data=1 stay stable; req_ready=0 throughout despite r0 valid; r0 is accepted only in the cycle after resp_ready[1] rises.
- **Pass-through select:** r0 sends sel=4'b1111, op2=0x12345000 → resp_data=0x12345000, confirming the select code reaches the ALU unchanged.
- **Reset mid-op:** assert rst_n=0 while in RESP → resp_valid=0 and busy=0 immediately (asynchronously); after release, both requesters valid → requester 0 is granted, showing rr_ptr was reset.
- **Wrong-port ready:** resp_ready[0]=1 while r1 owns RESP → no completion; state stays RESP until resp_ready[1]=1.
